lbp_histogram: RTL and testbench

//  Downstream consumer of the LBP engine's write port (lbp_valid/lbp_addr/lbp_data/finish).
//  - ACCUM: builds a 256-bin histogram of LBP codes over one 128x128 frame (interior pixels only).
//  - DUMP: on the finish rising edge, streams the bins out over a valid/ready port, clearing each bin as it is accepted.

---
 rtl/lbp_histogram.sv | 146 ++++++++++++++
 tb/tb_lbp_histogram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_histogram.sv
// Histogram of LBP codes over the interior pixels of one frame; streams and clears the bins on finish.
// Latency: a sample is visible in its bin one cycle later; the first dump word is valid one cycle after finish rises.
// Backpressure: dump words hold while hist_ready is low; samples that arrive during a dump are dropped and flagged.
//
// Ports:
//   clk, reset                           clock (rising edge) and asynchronous active-high reset
//   lbp_valid/lbp_addr/lbp_data          sample strobe, pixel address (row*IMG_W+col), LBP code (= bin index)
//   finish                               frame-complete level; its rising edge starts a dump
//   hist_valid/hist_ready                dump handshake
//   hist_bin/hist_count                  bin index and its count, count read combinationally from storage
//   hist_done                            one-cycle pulse after bin 255 is accepted
//   busy                                 high while dumping
//   pix_count                            interior samples counted this frame
//   addr_err/ovr_err                     sticky: border sample seen / sample arrived during a dump
module lbp_histogram #(
    parameter int CNT_W = 14,
    parameter int IMG_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             busy,
    output logic [CNT_W-1:0] pix_count,
    output logic             addr_err,
    output logic             ovr_err
);

    typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_t;

    localparam logic [13:0]      IMG_W14 = 14'(IMG_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bin_q [256];
    logic [CNT_W-1:0] bin_d [256];
    logic [7:0]       hist_bin_q, hist_bin_d;
    logic             hist_done_q, hist_done_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;
    logic             addr_err_q, addr_err_d;
    logic             ovr_err_q, ovr_err_d;
    logic             fin_q;

    logic             fin_rise;
    logic [13:0]      row, col;
    logic             border;

    assign fin_rise = finish & ~fin_q;
    assign row      = lbp_addr / IMG_W14;
    assign col      = lbp_addr % IMG_W14;
    // Anything on or beyond the last row also counts as border.
    assign border   = (row == 14'd0) || (row >= IMG_W14 - 14'd1) ||
                      (col == 14'd0) || (col == IMG_W14 - 14'd1);

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        hist_bin_d  = hist_bin_q;
        hist_done_d = 1'b0;
        pix_count_d = pix_count_q;
        addr_err_d  = addr_err_q;
        ovr_err_d   = ovr_err_q;

        case (state_q)
            ACCUM: begin
                if (lbp_valid) begin
                    if (border) begin
                        addr_err_d = 1'b1;
                    end else begin
                        // Read-modify-write straight from the registered array,
                        // so back-to-back hits on one bin never lose a count.
                        if (bin_q[lbp_data] != CNT_MAX) begin
                            bin_d[lbp_data] = bin_q[lbp_data] + 1'b1;
                        end
                        if (pix_count_q != CNT_MAX) begin
                            pix_count_d = pix_count_q + 1'b1;
                        end
                    end
                end
                if (fin_rise) begin
                    state_d    = DUMP;
                    hist_bin_d = 8'd0;
                end
            end
            DUMP: begin
                if (lbp_valid) begin
                    ovr_err_d = 1'b1;
                end
                if (hist_ready) begin
                    bin_d[hist_bin_q] = '0;
                    if (hist_bin_q == 8'd255) begin
                        state_d     = ACCUM;
                        hist_bin_d  = 8'd0;
                        hist_done_d = 1'b1;
                        pix_count_d = '0;
                    end else begin
                        hist_bin_d = hist_bin_q + 8'd1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            for (int i = 0; i < 256; i++) begin
                bin_q[i] <= '0;
            end
            hist_bin_q  <= 8'd0;
            hist_done_q <= 1'b0;
            pix_count_q <= '0;
            addr_err_q  <= 1'b0;
            ovr_err_q   <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            hist_bin_q  <= hist_bin_d;
            hist_done_q <= hist_done_d;
            pix_count_q <= pix_count_d;
            addr_err_q  <= addr_err_d;
            ovr_err_q   <= ovr_err_d;
            fin_q       <= finish;
        end
    end

    // valid and busy are both exactly "in DUMP".
    assign hist_valid = (state_q == DUMP);
    assign busy       = (state_q == DUMP);
    assign hist_bin   = hist_bin_q;
    assign hist_count = bin_q[hist_bin_q];
    assign hist_done  = hist_done_q;
    assign pix_count  = pix_count_q;
    assign addr_err   = addr_err_q;
    assign ovr_err    = ovr_err_q;

endmodule

// File: tb/tb_lbp_histogram.sv
module tb_lbp_histogram;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic        hist_done;
    logic        busy;
    logic [13:0] pix_count;
    logic        addr_err;
    logic        ovr_err;

    int errors = 0;
    int checks = 0;
    int exp_bins [256];

    lbp_histogram #(.CNT_W(14), .IMG_W(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done),
        .busy       (busy),
        .pix_count  (pix_count),
        .addr_err   (addr_err),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int addr, input int code);
        lbp_valid = 1'b1;
        lbp_addr  = 14'(addr);
        lbp_data  = 8'(code);
        step();
        lbp_valid = 1'b0;
    endtask

    task automatic start_dump(input bit keep_high);
        finish = 1'b1;
        step();
        chk("dump_latency_valid", 32'(hist_valid), 32'd1);
        chk("dump_start_busy", 32'(busy), 32'd1);
        chk("dump_start_bin", 32'(hist_bin), 32'd0);
        if (!keep_high) finish = 1'b0;
    endtask

    // Drain a whole dump, comparing every word against exp_bins, then clear exp_bins.
    task automatic dump_check(input bit rand_rdy);
        int  k;
        int  cyc;
        int  guard;
        bit  r;
        guard = 0;
        while (!hist_valid && guard < 10) begin
            step();
            guard++;
        end
        chk("dump_valid_seen", 32'(hist_valid), 32'd1);
        if (hist_valid) begin
            k   = 0;
            cyc = 0;
            while (k < 256 && cyc < 256 * 64) begin
                r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                hist_ready = r;
                // Repeated while not accepted, so this also proves the word stays stable.
                if (hist_valid !== 1'b1 || hist_bin !== 8'(k) || 32'(hist_count) !== exp_bins[k]) begin
                    chk("dump_valid", 32'(hist_valid), 32'd1);
                    chk("dump_bin", 32'(hist_bin), 32'(k));
                    chk("dump_count", 32'(hist_count), 32'(exp_bins[k]));
                end else begin
                    checks++;
                end
                step();
                cyc++;
                if (r) k++;
            end
            hist_ready = 1'b0;
            chk("dump_all_bins_emitted", 32'(k), 32'd256);
            if (!rand_rdy) chk("dump_cycles", 32'(cyc), 32'd256);
            chk("done_pulse", 32'(hist_done), 32'd1);
            chk("done_valid_low", 32'(hist_valid), 32'd0);
            chk("done_busy_low", 32'(busy), 32'd0);
            chk("done_pix_clear", 32'(pix_count), 32'd0);
            step();
            chk("done_one_cycle", 32'(hist_done), 32'd0);
        end
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
    endtask

    initial begin
        reset      = 1'b1;
        lbp_valid  = 1'b0;
        lbp_addr   = 14'd0;
        lbp_data   = 8'd0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(hist_valid), 32'd0);
        chk("rst_bin", 32'(hist_bin), 32'd0);
        chk("rst_count", 32'(hist_count), 32'd0);
        chk("rst_done", 32'(hist_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pix", 32'(pix_count), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_ovr_err", 32'(ovr_err), 32'd0);
        reset = 1'b0;
        step();

        // 1: reset mid-frame after 5 samples, then a dump of zeros
        for (int i = 0; i < 5; i++) send(129, 0);
        chk("t1_pix_before_rst", 32'(pix_count), 32'd5);
        chk("t1_bin0_before_rst", 32'(hist_count), 32'd5);
        reset = 1'b1;
        #2;
        chk("t1_rst_pix", 32'(pix_count), 32'd0);
        chk("t1_rst_count", 32'(hist_count), 32'd0);
        chk("t1_rst_valid", 32'(hist_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        start_dump(1'b0);
        dump_check(1'b0);

        // 2: three samples of 0x5A at row1,col1
        for (int i = 0; i < 3; i++) send(129, 8'h5A);
        chk("t2_pix", 32'(pix_count), 32'd3);
        exp_bins[8'h5A] = 3;
        start_dump(1'b0);
        dump_check(1'b0);
        chk("t2_addr_err_clear", 32'(addr_err), 32'd0);

        // 4: border addresses are dropped
        send(0, 1);
        send(127, 1);
        send(16383, 1);
        chk("t4_addr_err", 32'(addr_err), 32'd1);
        chk("t4_pix", 32'(pix_count), 32'd0);

        // 3: full interior frame, code = col
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                lbp_valid = 1'b1;
                lbp_addr  = 14'(r * 128 + c);
                lbp_data  = 8'(c);
                step();
            end
        end
        lbp_valid = 1'b0;
        chk("t3_pix", 32'(pix_count), 32'd15876);
        for (int i = 1; i <= 126; i++) exp_bins[i] = 126;
        start_dump(1'b0);
        dump_check(1'b0);

        // 5: random backpressure; sample on the finish edge is counted
        send(200, 9);
        send(300, 9);
        send(1000, 200);
        lbp_valid = 1'b1;
        lbp_addr  = 14'd1000;
        lbp_data  = 8'd200;
        finish    = 1'b1;
        step();
        lbp_valid = 1'b0;
        finish    = 1'b0;
        chk("t5_dump_started", 32'(hist_valid), 32'd1);
        chk("t5_pix_edge_sample", 32'(pix_count), 32'd4);
        exp_bins[9]   = 2;
        exp_bins[200] = 2;
        dump_check(1'b1);
        start_dump(1'b0);
        dump_check(1'b0);

        // 6: sample during dump sets ovr_err; finish held high does not retrigger
        chk("t6_ovr_clear", 32'(ovr_err), 32'd0);
        send(129, 7);
        send(129, 7);
        start_dump(1'b1);
        lbp_valid = 1'b1;
        lbp_addr  = 14'd129;
        lbp_data  = 8'd7;
        step();
        lbp_valid = 1'b0;
        chk("t6_ovr_err", 32'(ovr_err), 32'd1);
        exp_bins[7] = 2;
        dump_check(1'b0);
        repeat (5) step();
        chk("t6_no_retrigger_valid", 32'(hist_valid), 32'd0);
        chk("t6_no_retrigger_busy", 32'(busy), 32'd0);
        finish = 1'b0;
        step();
        start_dump(1'b0);
        dump_check(1'b0);
        chk("t6_addr_err_sticky", 32'(addr_err), 32'd1);
        chk("t6_ovr_err_sticky", 32'(ovr_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
